fifo_traffic_checker: RTL

- Synthesizable stimulus and checker engine for the Pango FIFO IP cores (sync/async, any width/depth).
- Drives the FIFO write port with a decrementing data pattern and reads it back.
- Checks read data against the expected sequence, checks full/empty flag behaviour, and reports a saturating error count plus a pass flag.
- Replaces per-IP hand-written benches. Adds a concurrent streaming mode, configurable read latency, multi-pass wrap-around and flag checking.

---
 rtl/fifo_traffic_checker.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_traffic_checker.sv
// fifo_traffic_checker: self-contained stimulus/checker engine for a FIFO.
// Writes a decrementing data pattern, reads it back through a latency-matched
// expectation pipe, counts data mismatches and watches the full/empty flags.
module fifo_traffic_checker #(
   parameter int DATA_WIDTH    = 11,
   parameter int DEPTH_WIDTH   = 10,
   parameter int RD_LATENCY    = 1,
   parameter int MODE          = 0,
   parameter int PASSES        = 4,
   parameter int GAP_CYCLES    = 8,
   parameter int ERR_CNT_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     tb_rst,
   input  logic                     start,
   output logic                     fifo_wr_en,
   output logic [DATA_WIDTH-1:0]    fifo_wr_data,
   input  logic                     fifo_wr_full,
   output logic                     fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
   input  logic                     fifo_rd_empty,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   output logic                     flag_err
);

   // word counters hold up to PASSES*DEPTH without wrapping
   localparam int WCW = DEPTH_WIDTH + $clog2(PASSES) + 1;
   localparam logic [WCW-1:0] DEPTH_W = WCW'(1) << DEPTH_WIDTH;
   localparam logic [WCW-1:0] TOTAL_W = WCW'(PASSES) << DEPTH_WIDTH;
   // one shared wait counter serves GAP and FLUSH; sized for the longer of the two
   localparam int WAIT_W = $clog2(GAP_CYCLES + RD_LATENCY + 2);
   localparam logic [WAIT_W-1:0] GAP_TGT   = WAIT_W'(GAP_CYCLES);
   localparam logic [WAIT_W-1:0] FLUSH_TGT = (MODE == 0) ? WAIT_W'(GAP_CYCLES) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_GAP, S_DRAIN, S_STREAM, S_FLUSH, S_DONE
   } state_t;

   state_t                                  state_q, state_d;
   logic                                    wr_en_q, wr_en_d;
   logic                                    rd_en_q, rd_en_d;
   logic [DATA_WIDTH-1:0]                   wr_cnt_q, wr_cnt_d;
   logic [DATA_WIDTH-1:0]                   exp_cnt_q, exp_cnt_d;
   logic [WCW-1:0]                          wr_words_q, wr_words_d;
   logic [WCW-1:0]                          rd_words_q, rd_words_d;
   logic [WAIT_W-1:0]                       wait_cnt_q, wait_cnt_d;
   logic [RD_LATENCY-1:0]                   vld_pipe_q, vld_pipe_d;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0]   dat_pipe_q, dat_pipe_d;
   logic                                    busy_q, busy_d;
   logic                                    done_q, done_d;
   logic [ERR_CNT_WIDTH-1:0]                err_cnt_q, err_cnt_d;
   logic                                    flag_err_q, flag_err_d;
   logic                                    wr_acc, rd_acc;
   logic                                    tail_mis;

   // transfer acceptance as the FIFO sees it
   always_comb begin
      wr_acc = wr_en_q & ~fifo_wr_full;
      rd_acc = rd_en_q & ~fifo_rd_empty;
   end

   // expectation pipe: an accepted read enters stage 0, the tail lines up with fifo_rd_data
   if (RD_LATENCY > 1) begin : g_pipe_n
      always_comb begin
         vld_pipe_d = {vld_pipe_q[RD_LATENCY-2:0], rd_acc};
         dat_pipe_d = {dat_pipe_q[RD_LATENCY-2:0], exp_cnt_q};
      end
   end else begin : g_pipe_1
      always_comb begin
         vld_pipe_d = rd_acc;
         dat_pipe_d = exp_cnt_q;
      end
   end

   // tail comparison against the returned read data
   always_comb begin
      tail_mis = vld_pipe_q[RD_LATENCY-1] && (dat_pipe_q[RD_LATENCY-1] != fifo_rd_data);
   end

   // next-state, counters, enables and checks
   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q - DATA_WIDTH'(wr_acc);
      exp_cnt_d  = exp_cnt_q - DATA_WIDTH'(rd_acc);
      wr_words_d = wr_words_q + WCW'(wr_acc);
      rd_words_d = rd_words_q + WCW'(rd_acc);
      wait_cnt_d = wait_cnt_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = done_q;
      flag_err_d = flag_err_q;
      err_cnt_d  = err_cnt_q;
      // saturating mismatch count
      if (tail_mis && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = (MODE == 1) ? S_STREAM : S_FILL;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_cnt_d  = '0;
               flag_err_d = 1'b0;
               wr_cnt_d   = '1;
               exp_cnt_d  = '1;
               wr_words_d = '0;
               rd_words_d = '0;
               wait_cnt_d = '0;
            end
         end
         S_FILL: begin
            // the cycle after the last accepted write the FIFO must report full
            if (wr_words_q == DEPTH_W) begin
               if (!fifo_wr_full) flag_err_d = 1'b1;
               state_d    = S_GAP;
               wait_cnt_d = '0;
            end else begin
               wr_en_d = (wr_words_d < DEPTH_W) && !fifo_wr_full;
            end
         end
         S_GAP: begin
            // idle so the flags can cross clock domains, then data must be visible
            if (wait_cnt_q == GAP_TGT) begin
               if (fifo_rd_empty) flag_err_d = 1'b1;
               state_d = S_DRAIN;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (rd_words_d == DEPTH_W) begin
               state_d    = S_FLUSH;
               wait_cnt_d = '0;
            end else begin
               rd_en_d = !fifo_rd_empty;
            end
         end
         S_STREAM: begin
            // reads never overtake writes already accepted
            wr_en_d = (wr_words_d < TOTAL_W) && !fifo_wr_full;
            if (rd_words_d == TOTAL_W) begin
               state_d    = S_FLUSH;
               wait_cnt_d = '0;
               wr_en_d    = 1'b0;
            end else begin
               rd_en_d = (rd_words_d < wr_words_d) && !fifo_rd_empty;
            end
         end
         S_FLUSH: begin
            if (wait_cnt_q != FLUSH_TGT) wait_cnt_d = wait_cnt_q + 1'b1;
            // all expected words compared and FIFO must have gone empty
            if ((wait_cnt_q == FLUSH_TGT) && (vld_pipe_q == '0)) begin
               if (!fifo_rd_empty) flag_err_d = 1'b1;
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers; reset aborts any run immediately
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_q    <= S_IDLE;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_cnt_q   <= '1;
         exp_cnt_q  <= '1;
         wr_words_q <= '0;
         rd_words_q <= '0;
         wait_cnt_q <= '0;
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_cnt_q  <= '0;
         flag_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         wr_cnt_q   <= wr_cnt_d;
         exp_cnt_q  <= exp_cnt_d;
         wr_words_q <= wr_words_d;
         rd_words_q <= rd_words_d;
         wait_cnt_q <= wait_cnt_d;
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_cnt_q  <= err_cnt_d;
         flag_err_q <= flag_err_d;
      end
   end

   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = wr_cnt_q;
   assign fifo_rd_en   = rd_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_cnt      = err_cnt_q;
   assign flag_err     = flag_err_q;
   assign pass         = done_q & (err_cnt_q == '0) & ~flag_err_q;

endmodule
